// File: rtl/instruction_loader.sv
// instruction_loader
// Feeds the IF-stage instruction memory from a byte stream (typically the
// UART debug unit). Bytes are packed MSB-first into instruction words. Each
// word is presented with a one-cycle write strobe. Loading stops on the HALT
// word or when the memory is full.

module instruction_loader #(
    parameter int                                 WORD_SIZE_IN_BYTES = 4,
    parameter int                                 MEM_SIZE_IN_WORDS  = 10,
    parameter logic [WORD_SIZE_IN_BYTES*8-1:0]    HALT_INSTRUCTION   = 32'hFFFFFFFF
) (
    input  logic                                        i_clk,
    input  logic                                        i_reset,
    input  logic                                        i_start,
    input  logic                                        i_byte_valid,
    input  logic [7:0]                                  i_byte,
    output logic                                        o_byte_ready,
    output logic [WORD_SIZE_IN_BYTES*8-1:0]             o_instruction,
    output logic                                        o_instruction_write,
    output logic [$clog2(MEM_SIZE_IN_WORDS+1)-1:0]      o_word_count,
    output logic                                        o_busy,
    output logic                                        o_done,
    output logic                                        o_overflow
);

    localparam int WORD_W  = WORD_SIZE_IN_BYTES * 8;
    localparam int COUNT_W = $clog2(MEM_SIZE_IN_WORDS + 1);
    localparam int IDX_W   = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1;

    localparam logic [IDX_W-1:0]   LAST_INDEX = IDX_W'(WORD_SIZE_IN_BYTES - 1);
    localparam logic [COUNT_W-1:0] MEM_WORDS  = COUNT_W'(MEM_SIZE_IN_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        ASSEMBLE,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   byte_index;
    logic [WORD_W-1:0]  shift_word;
    logic [WORD_W-1:0]  next_word;
    logic [COUNT_W-1:0] next_count;

    // Word as it stands once the byte currently on i_byte is shifted in, and
    // the count after the word in WRITE has been committed.
    always_comb begin
        next_word  = {shift_word[WORD_W-9:0], i_byte};
        next_count = o_word_count + COUNT_W'(1);
    end

    // Load sequencer: all outputs are registered and follow the state, so the
    // handshake and strobe never depend combinationally on the inputs.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state               <= IDLE;
            byte_index          <= '0;
            shift_word          <= '0;
            o_instruction       <= '0;
            o_instruction_write <= 1'b0;
            o_word_count        <= '0;
            o_byte_ready        <= 1'b0;
            o_busy              <= 1'b0;
            o_done              <= 1'b0;
            o_overflow          <= 1'b0;
        end else begin
            o_instruction_write <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (i_start) begin
                        state        <= ASSEMBLE;
                        byte_index   <= '0;
                        shift_word   <= '0;
                        o_word_count <= '0;
                        o_done       <= 1'b0;
                        o_overflow   <= 1'b0;
                        o_byte_ready <= 1'b1;
                        o_busy       <= 1'b1;
                    end
                end
                ASSEMBLE: begin
                    if (i_byte_valid && o_byte_ready) begin
                        shift_word <= next_word;
                        if (byte_index == LAST_INDEX) begin
                            state               <= WRITE;
                            byte_index          <= '0;
                            o_instruction       <= next_word;
                            o_instruction_write <= 1'b1;
                            o_byte_ready        <= 1'b0;
                        end else begin
                            byte_index <= byte_index + IDX_W'(1);
                        end
                    end
                end
                WRITE: begin
                    o_word_count <= next_count;
                    if (o_instruction == HALT_INSTRUCTION) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                    end else if (next_count == MEM_WORDS) begin
                        state      <= ERROR;
                        o_overflow <= 1'b1;
                        o_busy     <= 1'b0;
                    end else begin
                        state        <= ASSEMBLE;
                        o_byte_ready <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    o_byte_ready <= 1'b0;
                    o_busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Testbench for instruction_loader: directed byte streams checked every
// cycle against a word-level model, plus literal expectations.

module tb_instruction_loader;

    localparam int          NB   = 4;
    localparam int          MEM  = 10;
    localparam int          W    = NB * 8;
    localparam logic [31:0] HALT = 32'hFFFFFFFF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          valid = 1'b0;
    logic [7:0]    data = 8'h00;
    logic          ready;
    logic [W-1:0]  instr;
    logic          wr;
    logic [3:0]    count;
    logic          busy;
    logic          done;
    logic          ovf;

    int vectors = 0;
    int miscompares = 0;
    int strobes = 0;

    instruction_loader #(
        .WORD_SIZE_IN_BYTES (NB),
        .MEM_SIZE_IN_WORDS  (MEM),
        .HALT_INSTRUCTION   (HALT)
    ) dut (
        .i_clk               (clk),
        .i_reset             (rst_n),
        .i_start             (start),
        .i_byte_valid        (valid),
        .i_byte              (data),
        .o_byte_ready        (ready),
        .o_instruction       (instr),
        .o_instruction_write (wr),
        .o_word_count        (count),
        .o_busy              (busy),
        .o_done              (done),
        .o_overflow          (ovf)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Word-level model: a load is either collecting bytes, emitting a word,
    // finished, or overflowed; words are built from a queue of bytes.
    bit          m_loading = 0;
    bit          m_emit = 0;
    bit          m_done = 0;
    bit          m_ovf = 0;
    int          m_count = 0;
    logic [31:0] m_word = 0;
    logic [7:0]  m_bytes[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_loading = 0; m_emit = 0; m_done = 0; m_ovf = 0;
            m_count = 0; m_word = 0; m_bytes.delete();
        end else if (m_emit) begin
            m_emit = 0;
            m_count++;
            if (m_word == HALT) begin
                m_loading = 0; m_done = 1;
            end else if (m_count == MEM) begin
                m_loading = 0; m_ovf = 1;
            end
        end else if (m_loading) begin
            if (valid) begin
                m_bytes.push_back(data);
                if (m_bytes.size() == NB) begin
                    m_word = 0;
                    for (int i = 0; i < NB; i++) m_word = (m_word << 8) | 32'(m_bytes[i]);
                    m_bytes.delete();
                    m_emit = 1;
                end
            end
        end else if (start) begin
            m_loading = 1; m_done = 0; m_ovf = 0; m_count = 0;
            m_bytes.delete();
        end
    end

    // Count write strobes seen at the memory interface
    always @(posedge clk) if (wr) strobes++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        checkOutput("byte_ready", 32'(ready), 32'(m_loading && !m_emit));
        checkOutput("busy", 32'(busy), 32'(m_loading));
        checkOutput("write", 32'(wr), 32'(m_emit));
        checkOutput("done", 32'(done), 32'(m_done));
        checkOutput("overflow", 32'(ovf), 32'(m_ovf));
        checkOutput("word_count", 32'(count), 32'(m_count));
        if (m_emit || m_done) checkOutput("instruction", instr, m_word);
    end

    // One clock with the given inputs; inputs change 2 time units after the edge
    task automatic applyStimulus(input logic s, input logic v, input logic [7:0] b);
        start = s; valid = v; data = b;
        @(posedge clk); #2;
    endtask

    task automatic pulseStart();
        applyStimulus(1'b1, 1'b0, 8'h00);
        start = 1'b0;
    endtask

    // Hold a byte on the handshake until it is taken, with a bounded wait
    task automatic sendByte(input logic [7:0] b, input int gap);
        bit taken;
        repeat (gap) applyStimulus(1'b0, 1'b0, 8'h00);
        valid = 1'b1; data = b;
        taken = 0;
        for (int t = 0; t < 100 && !taken; t++) begin
            @(negedge clk); taken = ready;
            @(posedge clk); #2;
        end
        valid = 1'b0;
        if (!taken) begin
            vectors++; miscompares++;
            $display("[TB] FAIL handshake_timeout: got no accept expected accept of %h", b);
        end
    endtask

    task automatic sendWord(input logic [31:0] w, input int max_gap);
        logic [31:0] tmp;
        tmp = w;
        for (int i = NB - 1; i >= 0; i--)
            sendByte(tmp[i*8 +: 8], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
    endtask

    initial begin
        // Reset with random byte activity: no strobe, all outputs low
        repeat (6) applyStimulus(1'b0, 1'($urandom_range(1, 0)), 8'($urandom_range(255, 0)));
        checkOutput("reset_outputs", {24'h0, ready, wr, busy, done, ovf, 3'b0}, 32'h0);
        checkOutput("reset_instr", instr, 32'h0);
        checkOutput("reset_strobes", 32'(strobes), 32'd0);
        valid = 1'b0;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        pulseStart();
        checkOutput("start_ready", 32'(ready), 32'd1);
        checkOutput("start_busy", 32'(busy), 32'd1);

        // Back-to-back word: strobe the cycle after the last byte edge
        strobes = 0;
        sendWord(32'h12345678, 0);
        checkOutput("w1_strobe", 32'(wr), 32'd1);
        checkOutput("w1_word", instr, 32'h12345678);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("w1_count", 32'(count), 32'd1);
        checkOutput("w1_strobes", 32'(strobes), 32'd1);

        // Same word with random gaps, then one more word held across WRITE
        sendWord(32'h12345678, 20);
        checkOutput("w2_word", instr, 32'h12345678);
        sendWord(32'hCAFE0001, 0);
        sendWord(HALT, 0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("w2_count", 32'(count), 32'd4);

        // Two-word program ending with HALT; trailing bytes ignored
        pulseStart();
        strobes = 0;
        sendWord(32'h20010005, 3);
        sendWord(HALT, 0);
        repeat (4) applyStimulus(1'b0, 1'b1, 8'h5A);
        valid = 1'b0;
        checkOutput("halt_done", 32'(done), 32'd1);
        checkOutput("halt_count", 32'(count), 32'd2);
        checkOutput("halt_ready", 32'(ready), 32'd0);
        checkOutput("halt_instr", instr, HALT);
        checkOutput("halt_strobes", 32'(strobes), 32'd2);

        // Ten ordinary words fill memory; an eleventh is refused
        pulseStart();
        strobes = 0;
        for (int k = 0; k < MEM; k++) sendWord(32'h00000100 + 32'(k), 1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        repeat (8) applyStimulus(1'b0, 1'b1, 8'h77);
        valid = 1'b0;
        checkOutput("ovf_flag", 32'(ovf), 32'd1);
        checkOutput("ovf_done", 32'(done), 32'd0);
        checkOutput("ovf_count", 32'(count), 32'd10);
        checkOutput("ovf_strobes", 32'(strobes), 32'd10);
        pulseStart();
        checkOutput("restart_count", 32'(count), 32'd0);
        checkOutput("restart_ovf", 32'(ovf), 32'd0);

        // Reset mid-word drops the partial bytes
        strobes = 0;
        sendByte(8'h11, 0);
        sendByte(8'h22, 0);
        rst_n = 1'b0;
        repeat (2) applyStimulus(1'b0, 1'b1, 8'h33);
        valid = 1'b0;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("midreset_strobes", 32'(strobes), 32'd0);
        pulseStart();
        sendWord(32'hAABBCCDD, 0);
        checkOutput("clean_word", instr, 32'hAABBCCDD);
        checkOutput("clean_strobe", 32'(wr), 32'd1);
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("clean_count", 32'(count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
